// File: rtl/cond_unit.sv
// Execute-stage condition/flag unit: holds the NZCV register, evaluates the
// instruction condition, gates write/branch controls into the M stage and
// squashes the wrong-path slots that follow a taken branch.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   Valid, Stall    real instruction present / pipeline hold
//   Cond            4-bit condition field
//   ALUFlags        NZCV from the ALU ([3]=N [2]=Z [1]=C [0]=V)
//   FlagW           [1] loads N,Z ; [0] loads C,V
//   PCS, RegW, MemW branch / register-write / memory-write requests
//   NoWrite         compare-type op, suppresses the register write
//   Flags           architectural NZCV register
//   CondEx, Squash  combinational execute / wrong-path indications
//   PCSrcM, RegWriteM, MemWriteM  registered gated controls
module cond_unit #(
    parameter int unsigned SHADOW_LEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Valid,
    input  logic       Stall,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic [3:0] Flags,
    output logic       CondEx,
    output logic       Squash,
    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemWriteM
);

    localparam int unsigned CW         = 3;
    localparam bit          HAS_SHADOW = (SHADOW_LEN != 0);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            condpass;
    logic            flag_n;
    logic            flag_z;
    logic            flag_c;
    logic            flag_v;
    logic            taken;

    assign flag_n = Flags[3];
    assign flag_z = Flags[2];
    assign flag_c = Flags[1];
    assign flag_v = Flags[0];

    // Condition field decode against the flags left by prior instructions.
    always_comb begin
        condpass = 1'b0;
        unique case (Cond)
            4'b0000: condpass = flag_z;
            4'b0001: condpass = !flag_z;
            4'b0010: condpass = flag_c;
            4'b0011: condpass = !flag_c;
            4'b0100: condpass = flag_n;
            4'b0101: condpass = !flag_n;
            4'b0110: condpass = flag_v;
            4'b0111: condpass = !flag_v;
            4'b1000: condpass = flag_c && !flag_z;
            4'b1001: condpass = !flag_c || flag_z;
            4'b1010: condpass = (flag_n == flag_v);
            4'b1011: condpass = (flag_n != flag_v);
            4'b1100: condpass = !flag_z && (flag_n == flag_v);
            4'b1101: condpass = flag_z || (flag_n != flag_v);
            4'b1110: condpass = 1'b1;
            4'b1111: condpass = 1'b0;
            default: condpass = 1'b0;
        endcase
    end

    // Squash FSM state register; stall freezes state and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else if (!Stall) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Squash FSM next-state logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            RUN: begin
                if (taken && HAS_SHADOW) begin
                    state_nxt = SHADOW;
                    cnt_nxt   = CW'(SHADOW_LEN);
                end
            end
            SHADOW: begin
                // Counts slots, not instructions: bubbles are consumed too.
                if (cnt <= CW'(1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Squash FSM outputs and execute qualification.
    always_comb begin
        Squash = (state == SHADOW);
        CondEx = Valid && condpass && !Squash;
        taken  = !Stall && CondEx && PCS;
    end

    // Flag register and M-stage controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags     <= 4'b0000;
            PCSrcM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else if (!Stall) begin
            if (CondEx && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (CondEx && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
            PCSrcM    <= CondEx && PCS;
            RegWriteM <= CondEx && RegW && !NoWrite;
            MemWriteM <= CondEx && MemW;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit with the default two-slot shadow.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       Valid;
    logic       Stall;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic [3:0] Flags;
    logic       CondEx;
    logic       Squash;
    logic       PCSrcM;
    logic       RegWriteM;
    logic       MemWriteM;

    int n_cmp = 0;
    int n_bad = 0;

    cond_unit #(.SHADOW_LEN(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .Valid     (Valid),
        .Stall     (Stall),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .PCS       (PCS),
        .RegW      (RegW),
        .MemW      (MemW),
        .NoWrite   (NoWrite),
        .Flags     (Flags),
        .CondEx    (CondEx),
        .Squash    (Squash),
        .PCSrcM    (PCSrcM),
        .RegWriteM (RegWriteM),
        .MemWriteM (MemWriteM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        Valid = 1'b0; Stall = 1'b0; Cond = 4'b1110; ALUFlags = 4'b0000;
        FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_pcsrc", 4'(PCSrcM), 4'd0);
        chk("rst_regw", 4'(RegWriteM), 4'd0);
        chk("rst_memw", 4'(MemWriteM), 4'd0);
        chk("rst_squash", 4'(Squash), 4'd0);

        // Unconditional ALU op setting all flags.
        Valid = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110; RegW = 1'b1;
        settle();
        chk("al_condex", 4'(CondEx), 4'd1);
        tick();
        chk("al_flags", Flags, 4'b0110);
        chk("al_regw", 4'(RegWriteM), 4'd1);
        chk("al_pcsrc", 4'(PCSrcM), 4'd0);
        chk("al_memw", 4'(MemWriteM), 4'd0);

        // Establish Flags=0100 (Z only).
        ALUFlags = 4'b0100; RegW = 1'b0;
        tick();
        chk("z_flags", Flags, 4'b0100);

        // EQ store executes.
        Cond = 4'b0000; FlagW = 2'b00; MemW = 1'b1;
        settle();
        chk("eq_condex", 4'(CondEx), 4'd1);
        tick();
        chk("eq_memw", 4'(MemWriteM), 4'd1);

        // NE store fails; flags untouched despite FlagW=11.
        Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b1011;
        settle();
        chk("ne_condex", 4'(CondEx), 4'd0);
        tick();
        chk("ne_memw", 4'(MemWriteM), 4'd0);
        chk("ne_flags", Flags, 4'b0100);

        // Partial flag update.
        MemW = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        chk("all1_flags", Flags, 4'b1111);
        FlagW = 2'b10; ALUFlags = 4'b0000;
        tick();
        chk("part_flags", Flags, 4'b0011);

        // CMP: flags update, register write suppressed.
        FlagW = 2'b11; ALUFlags = 4'b1000; RegW = 1'b1; NoWrite = 1'b1;
        tick();
        chk("cmp_regw", 4'(RegWriteM), 4'd0);
        chk("cmp_flags", Flags, 4'b1000);

        // Signed compares with N=1, V=0, Z=0, C=0.
        FlagW = 2'b00; RegW = 1'b0; NoWrite = 1'b0;
        Cond = 4'b1011; settle(); chk("lt_condex", 4'(CondEx), 4'd1);
        Cond = 4'b1010; settle(); chk("ge_condex", 4'(CondEx), 4'd0);
        Cond = 4'b1101; settle(); chk("le_condex", 4'(CondEx), 4'd1);
        Cond = 4'b1100; settle(); chk("gt_condex", 4'(CondEx), 4'd0);
        Cond = 4'b1000; settle(); chk("hi_condex", 4'(CondEx), 4'd0);
        Cond = 4'b1001; settle(); chk("ls_condex", 4'(CondEx), 4'd1);
        Cond = 4'b1111; settle(); chk("nv_condex", 4'(CondEx), 4'd0);

        // Taken branch opens a two-slot shadow.
        Cond = 4'b1110; PCS = 1'b1;
        tick();
        chk("br_pcsrc", 4'(PCSrcM), 4'd1);
        chk("br_squash", 4'(Squash), 4'd1);

        // Shadow slot 1.
        PCS = 1'b0; RegW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0101;
        settle();
        chk("s1_condex", 4'(CondEx), 4'd0);
        tick();
        chk("s1_regw", 4'(RegWriteM), 4'd0);
        chk("s1_pcsrc", 4'(PCSrcM), 4'd0);
        chk("s1_flags", Flags, 4'b1000);
        chk("s1_squash", 4'(Squash), 4'd1);

        // Stall with counter at 1 holds the shadow.
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_squash", 4'(Squash), 4'd1);
            chk("stl_regw", 4'(RegWriteM), 4'd0);
            chk("stl_flags", Flags, 4'b1000);
        end

        // Shadow slot 2, then back to RUN.
        Stall = 1'b0;
        settle();
        chk("s2_condex", 4'(CondEx), 4'd0);
        tick();
        chk("s2_squash", 4'(Squash), 4'd0);
        chk("s2_regw", 4'(RegWriteM), 4'd0);
        chk("s2_flags", Flags, 4'b1000);

        // Third slot executes normally.
        settle();
        chk("s3_condex", 4'(CondEx), 4'd1);
        tick();
        chk("s3_regw", 4'(RegWriteM), 4'd1);
        chk("s3_flags", Flags, 4'b0101);

        // Stall beats a taken branch.
        Stall = 1'b1; PCS = 1'b1; ALUFlags = 4'b1010;
        tick();
        chk("sb_squash", 4'(Squash), 4'd0);
        chk("sb_pcsrc", 4'(PCSrcM), 4'd0);
        chk("sb_regw", 4'(RegWriteM), 4'd1);
        chk("sb_flags", Flags, 4'b0101);
        Stall = 1'b0;
        tick();
        chk("sb2_pcsrc", 4'(PCSrcM), 4'd1);
        chk("sb2_squash", 4'(Squash), 4'd1);
        chk("sb2_flags", Flags, 4'b1010);

        // Reset mid-shadow.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_flags", Flags, 4'b0000);
        chk("rs_squash", 4'(Squash), 4'd0);
        chk("rs_pcsrc", 4'(PCSrcM), 4'd0);

        // Bubble: nothing executes, M outputs load 0.
        idle();
        RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
        settle();
        chk("bub_condex", 4'(CondEx), 4'd0);
        tick();
        chk("bub_regw", 4'(RegWriteM), 4'd0);
        chk("bub_memw", 4'(MemWriteM), 4'd0);
        chk("bub_squash", 4'(Squash), 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Execute-stage condition and flag unit that sits directly downstream of the ALU and consumes its 4-bit ALUFlags output.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against it.
- Gates register-write, memory-write and branch controls, then registers them into the next pipeline stage.
- Squashes the wrong-path instructions that follow a taken branch.

Parameters:
- SHADOW_LEN, default 2: number of issue slots squashed after a taken branch. Legal range 0..7.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Valid  in  1  the execute stage holds a real instruction.
- Stall  in  1  pipeline hold; freezes all state.
- Cond  in  4  instruction condition field.
- ALUFlags  in  4  ALU flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- FlagW  in  2  [1] updates N,Z; [0] updates C,V.
- PCS  in  1  instruction writes the PC (branch).
- RegW  in  1  instruction writes the register file.
- MemW  in  1  instruction writes memory.
- NoWrite  in  1  compare-type instruction; suppresses the register write.
- Flags  out  4  current NZCV register, same bit order as ALUFlags.
- CondEx  out  1  combinational: the instruction executes this cycle.
- Squash  out  1  combinational: the unit is in the SHADOW state.
- PCSrcM  out  1  registered, gated branch-taken signal.
- RegWriteM  out  1  registered, gated register write.
- MemWriteM  out  1  registered, gated memory write.

Behaviour:
- Reset: Flags=0000, PCSrcM=RegWriteM=MemWriteM=0, state=RUN, shadow counter=0. Reset has priority over Stall and every other input.
- Condition evaluation against the Flags register (flags left by prior instructions):
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V.
  - 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V).
  - 1110 always true; 1111 always false.
- CondEx = Valid & condpass & !Squash.
- Flag register update at the edge when !Stall & CondEx:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
  - Unselected bits hold.
  - FlagW=00 or CondEx=0: the register holds.
- Registered outputs, updated at the edge when !Stall:
  - PCSrcM <= CondEx & PCS
  - RegWriteM <= CondEx & RegW & !NoWrite
  - MemWriteM <= CondEx & MemW
- Latency: exactly one cycle from inputs to the M outputs. Under Stall, all M outputs, Flags, state and counter hold their values.
- Squash FSM:
  - RUN: a taken branch (!Stall & CondEx & PCS) with SHADOW_LEN>0 moves to SHADOW and loads the counter with SHADOW_LEN. With SHADOW_LEN=0 the unit stays in RUN.
  - SHADOW: Squash=1. On each non-stalled edge the counter decrements whether or not Valid is set. When the counter would reach 0, the next state is RUN. Squashed instructions never update Flags or assert any M output.
- A branch cannot be taken while in SHADOW, because it is squashed.
- Reset asserted mid-SHADOW returns to RUN on the next edge.
- Stall and a taken branch in the same cycle: Stall wins; nothing commits and the branch is re-evaluated on the next non-stalled cycle.
- Valid=0: CondEx=0; the M outputs load 0 on a non-stalled edge.
- The ALUFlags value is used only when FlagW selects it. An undefined ALU result on a non-flag-setting operation has no effect.

Test Plan:
- Reset, then Cond=1110, FlagW=11, ALUFlags=0110, RegW=1, NoWrite=0 -> next cycle Flags=0110, RegWriteM=1, PCSrcM=0, MemWriteM=0.
- With Flags=0100 (Z=1): Cond=0000 with MemW=1 gives MemWriteM=1 next cycle. Cond=0001 with MemW=1 gives CondEx=0, MemWriteM=0, and the Flags are unchanged even with FlagW=11.
- Partial update: Flags=1111, FlagW=10, ALUFlags=0000, Cond=1110 -> Flags=0011. A CMP with NoWrite=1, RegW=1 -> RegWriteM=0 while the flags still update.
- Taken branch (Cond=1110, PCS=1), SHADOW_LEN=2 -> PCSrcM=1 next cycle. The following two slots (Valid=1, RegW=1, FlagW=11) show Squash=1, CondEx=0, RegWriteM=0 and Flags unchanged. The third slot executes normally.
- Stall=1 for 3 cycles during SHADOW with the counter at 1 -> Squash stays 1 and all M outputs hold. After Stall drops, one edge returns the FSM to RUN.
- Signed compares: Flags N=1, V=0 -> Cond 1011 true, 1010 false, 1101 true. Cond=1111 is always false. reset=1 mid-SHADOW -> Flags=0000, Squash=0 after the edge.
